tone_sequencer: RTL

//  Buffered, parametrised buzzer note player. Accepts {octave, note, length, full_note}

---
 rtl/tone_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// Buffered square-wave note player: descriptors queue in a FIFO and play back-to-back.
// Optional macro TONE_GAP_EN inserts a silent GAP of GAP_TICKS ticks after every note.
module tone_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_CYCLES = 100_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int PERIOD_BITS = 24,
  parameter int DUR_BITS    = 32,
  parameter int GAP_TICKS   = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    octave,
  input  logic [2:0]                    note,
  input  logic [2:0]                    length,
  input  logic [7:0]                    full_note,
  input  logic                          flush,
  output logic                          buzzer,
  output logic                          busy,
  output logic                          note_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
`ifdef TONE_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam logic [DUR_BITS-1:0] GAP_LEN = DUR_BITS'(GAP_TICKS * TICK_CYCLES);
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_TICKS < 0 ||
      64'd255 * 64'(TICK_CYCLES) > ((64'd1 << DUR_BITS) - 64'd1) ||
      64'(GAP_TICKS) * 64'(TICK_CYCLES) > ((64'd1 << DUR_BITS) - 64'd1)) begin : g_bad_cfg
    $error("tone_sequencer: invalid parameter set");
  end

  // Octave-4 half-periods scaled from the 100 MHz reference, folded at elaboration.
  function automatic logic [63:0] base_half(input logic [2:0] n);
    case (n)
      3'd0:    return (64'd191110 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd1:    return (64'd170265 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd2:    return (64'd151685 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd3:    return (64'd143172 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd4:    return (64'd127551 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd5:    return (64'd113636 * 64'(CLK_HZ)) / 64'd100_000_000;
      3'd6:    return (64'd101239 * 64'(CLK_HZ)) / 64'd100_000_000;
      default: return 64'd1;
    endcase
  endfunction

  function automatic logic [PERIOD_BITS-1:0] sat_half(input logic [63:0] v);
    if (v > ((64'd1 << PERIOD_BITS) - 64'd1)) return {PERIOD_BITS{1'b1}};
    else if (v == 64'd0)                       return PERIOD_BITS'(1);
    else                                        return v[PERIOD_BITS-1:0];
  endfunction

  logic [16:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [1:0]             state;
  logic [PERIOD_BITS-1:0] cur_half, phase_cnt, load_half;
  logic [DUR_BITS-1:0]    cur_dur, dur_cnt, load_dur;
  logic                   cur_rest;
  logic [16:0]            head;
  logic [63:0]            base, shifted;
  logic                   push, pop, dur_last;

  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign pop        = (state == S_LOAD) && !flush;
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  assign dur_last   = (cur_dur == '0) || (dur_cnt == cur_dur - DUR_BITS'(1));

  always_comb begin
    base    = base_half(head[13:11]);
    shifted = '0;
    if (head[16:14] < 3'd4) shifted = base << (3'd4 - head[16:14]);
    else                    shifted = base >> (head[16:14] - 3'd4);
    load_half = sat_half(shifted);
    load_dur  = (DUR_BITS'(head[7:0]) * DUR_BITS'(TICK_CYCLES)) >> head[10:8];
  end

  // Datapath storage: queue entries and the latched note, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {octave, note, length, full_note};
    if (state == S_LOAD) begin
      cur_half <= load_half;
      cur_dur  <= load_dur;
      cur_rest <= (head[13:11] == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= S_IDLE;
      buzzer    <= 1'b0;
      note_done <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      phase_cnt <= '0;
      dur_cnt   <= '0;
    end else begin
      note_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      case (state)
        S_IDLE: if (count != '0) state <= S_LOAD;
        S_LOAD: begin
          phase_cnt <= '0;
          dur_cnt   <= '0;
          buzzer    <= 1'b0;
          state     <= S_PLAY;
        end
        S_PLAY: begin
          if (dur_last) begin
            note_done <= 1'b1;
            buzzer    <= 1'b0;
            dur_cnt   <= '0;
`ifdef TONE_GAP_EN
            state     <= S_GAP;
`else
            state     <= (count != '0) ? S_LOAD : S_IDLE;
`endif
          end else begin
            dur_cnt <= dur_cnt + DUR_BITS'(1);
            if (phase_cnt == cur_half - PERIOD_BITS'(1)) begin
              phase_cnt <= '0;
              if (!cur_rest) buzzer <= ~buzzer;
            end else begin
              phase_cnt <= phase_cnt + PERIOD_BITS'(1);
            end
          end
        end
`ifdef TONE_GAP_EN
        S_GAP: begin
          if (GAP_LEN == '0 || dur_cnt == GAP_LEN - DUR_BITS'(1))
            state <= (count != '0) ? S_LOAD : S_IDLE;
          else
            dur_cnt <= dur_cnt + DUR_BITS'(1);
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
